// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
//
// Arbitrates the single register-file write port between the pipeline
// writeback path (WB, never back-pressured, highest priority) and a
// multi-cycle unit (MD) whose results are buffered in a 2-entry FIFO.
// A 32-bit scoreboard tracks registers with an outstanding multi-cycle
// write, and a sticky error flag records protocol violations.
//
// Optional feature: define RF_ARB_STARVE_GUARD_EN to enable the starvation
// guard. A FIFO head that has waited 4 cycles behind WB is then forced out
// in a cycle where stall_req=1 tells the pipeline to hold off WB.
// Without the macro, stall_req is tied to 0 and the FIFO head waits for WB
// to go idle.
//
// Ports
//   clk            clock; all state updates on its rising edge
//   rst            synchronous active-high reset
//   wb_valid/addr/data      writeback request (no ready)
//   md_valid/addr/data      multi-cycle result, transferred on valid & ready
//   md_ready       FIFO not full (combinational from FIFO count only)
//   md_issue/md_issue_addr  multi-cycle op dispatched to md_issue_addr
//   WE3/A3/WD3     registered register-file write port
//   busy_vec       registered scoreboard, bit n = register n pending
//   stall_req      registered, pipeline must hold wb_valid=0
//   err            registered, sticky protocol-violation flag
// ---------------------------------------------------------------------------
module rf_write_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        md_valid,
    input  logic [4:0]  md_addr,
    input  logic [31:0] md_data,
    output logic        md_ready,
    input  logic        md_issue,
    input  logic [4:0]  md_issue_addr,
    output logic        WE3,
    output logic [4:0]  A3,
    output logic [31:0] WD3,
    output logic [31:0] busy_vec,
    output logic        stall_req,
    output logic        err
);

    // -----------------------------------------------------------------------
    // 2-entry FIFO
    // -----------------------------------------------------------------------
    logic [4:0]  r_fifo_addr [2];
    logic [31:0] r_fifo_data [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;

    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic [4:0]  w_head_addr;
    logic [31:0] w_head_data;

    logic        w_force;     // starvation guard forces the FIFO head out
    logic        w_wb_viol;   // wb_valid while stall_req (guard build only)
    logic        w_wb_win;

    logic        r_we3;
    logic [4:0]  r_a3;
    logic [31:0] r_wd3;
    logic [31:0] r_busy;
    logic [31:0] w_busy_nxt;
    logic        r_err;
    logic        w_err_now;

    assign w_empty     = (r_count == 2'd0);
    assign md_ready    = (r_count != 2'd2);
    assign w_push      = md_valid && md_ready;
    assign w_head_addr = r_fifo_addr[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];

    // WB wins unless it targets r0 or the starvation guard is forcing the head.
    assign w_wb_win = wb_valid && (wb_addr != 5'd0) && !w_force;
    // The head leaves whenever WB does not win; an r0 head is popped silently.
    assign w_pop    = !w_empty && !w_wb_win;

    // NOTE: FIFO storage has no reset; emptiness is defined by r_count and the
    // pointers, so stale payload is never observable and needs no clearing.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= md_addr;
            r_fifo_data[r_wr_ptr] <= md_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Starvation guard
    // -----------------------------------------------------------------------
`ifdef RF_ARB_STARVE_GUARD_EN
    logic [2:0] r_starve_cnt;
    logic [2:0] w_starve_cnt_nxt;
    logic       r_stall;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can infer a latch.
    always_comb begin
        w_starve_cnt_nxt = 3'd0;
        if (!w_empty && !w_pop)
            w_starve_cnt_nxt = r_starve_cnt + 3'd1;
    end

    // stall_req is registered off the next count, so it is high in exactly
    // the cycle the counter reads 4; the forced pop then clears the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= 3'd0;
            r_stall      <= 1'b0;
        end else begin
            r_starve_cnt <= w_starve_cnt_nxt;
            r_stall      <= (w_starve_cnt_nxt == 3'd4);
        end
    end

    assign w_force   = r_stall;
    assign w_wb_viol = wb_valid && r_stall;
    assign stall_req = r_stall;
`else
    assign w_force   = 1'b0;
    assign w_wb_viol = 1'b0;
    assign stall_req = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Register-file write port
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we3 <= 1'b0;
            r_a3  <= 5'd0;
            r_wd3 <= 32'd0;
        end else if (w_wb_win) begin
            r_we3 <= 1'b1;
            r_a3  <= wb_addr;
            r_wd3 <= wb_data;
        end else if (w_pop && (w_head_addr != 5'd0)) begin
            r_we3 <= 1'b1;
            r_a3  <= w_head_addr;
            r_wd3 <= w_head_data;
        end else begin
            r_we3 <= 1'b0;
        end
    end

    assign WE3 = r_we3;
    assign A3  = r_a3;
    assign WD3 = r_wd3;

    // -----------------------------------------------------------------------
    // Scoreboard: clear on grant of the FIFO head, then set so set wins.
    // -----------------------------------------------------------------------
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_pop)
            w_busy_nxt[w_head_addr] = 1'b0;
        if (md_issue && (md_issue_addr != 5'd0))
            w_busy_nxt[md_issue_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) r_busy <= 32'd0;
        else     r_busy <= w_busy_nxt;
    end

    assign busy_vec = r_busy;

    // -----------------------------------------------------------------------
    // Sticky protocol error
    // -----------------------------------------------------------------------
    assign w_err_now = (md_issue && (md_issue_addr != 5'd0) && r_busy[md_issue_addr])
                     || (w_push && (md_addr != 5'd0) && !r_busy[md_addr])
                     || w_wb_viol;

    always_ff @(posedge clk) begin
        if (rst)            r_err <= 1'b0;
        else if (w_err_now) r_err <= 1'b1;
    end

    assign err = r_err;

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        md_valid;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        md_ready;
    logic        md_issue;
    logic [4:0]  md_issue_addr;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic [31:0] busy_vec;
    logic        stall_req;
    logic        err;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    rf_write_arbiter dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data),
        .md_ready(md_ready),
        .md_issue(md_issue), .md_issue_addr(md_issue_addr),
        .WE3(WE3), .A3(A3), .WD3(WD3),
        .busy_vec(busy_vec), .stall_req(stall_req), .err(err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: pending MD results as a queue, scoreboard as a set
    // of register numbers, waiting time as a plain integer.
    // ---------------------------------------------------------------------
    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    ent_t        m_q[$];
    bit          m_busy[32];
    int          m_wait;
    bit          m_stall;
    bit          m_we;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;
    bit          m_err;

    function automatic logic [31:0] busy_word();
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 32; i++) w[i] = m_busy[i];
        return w;
    endfunction

    task automatic model_step();
        bit   force_head, wb_wins, head_out, accepted;
        ent_t head;
        if (rst) begin
            m_q.delete();
            for (int i = 0; i < 32; i++) m_busy[i] = 0;
            m_wait = 0; m_stall = 0; m_we = 0; m_a3 = 0; m_wd = 0; m_err = 0;
            return;
        end
`ifdef RF_ARB_STARVE_GUARD_EN
        force_head = m_stall;
`else
        force_head = 0;
`endif
        wb_wins  = wb_valid && (wb_addr != 0) && !force_head;
        head_out = (m_q.size() > 0) && !wb_wins;
        accepted = md_valid && (m_q.size() < 2);
        if (m_q.size() > 0) head = m_q[0];
        else head = '0;

        if (md_issue && md_issue_addr != 0 && m_busy[md_issue_addr]) m_err = 1;
        if (accepted && md_addr != 0 && !m_busy[md_addr]) m_err = 1;
`ifdef RF_ARB_STARVE_GUARD_EN
        if (wb_valid && m_stall) m_err = 1;
`endif
        if (wb_wins) begin
            m_we = 1; m_a3 = wb_addr; m_wd = wb_data;
        end else if (head_out && head.addr != 0) begin
            m_we = 1; m_a3 = head.addr; m_wd = head.data;
        end else begin
            m_we = 0;
        end

        if (head_out) m_busy[head.addr] = 0;
        if (md_issue && md_issue_addr != 0) m_busy[md_issue_addr] = 1;

`ifdef RF_ARB_STARVE_GUARD_EN
        if (m_q.size() > 0 && !head_out) m_wait++;
        else m_wait = 0;
        m_stall = (m_wait == 4);
`endif
        if (head_out) void'(m_q.pop_front());
        if (accepted) m_q.push_back('{addr: md_addr, data: md_data});
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("WE3",       {31'd0, WE3},       {31'd0, m_we});
        check("A3",        {27'd0, A3},        {27'd0, m_a3});
        check("WD3",       WD3,                m_wd);
        check("busy_vec",  busy_vec,           busy_word());
        check("stall_req", {31'd0, stall_req}, {31'd0, m_stall});
        check("err",       {31'd0, err},       {31'd0, m_err});
        check("md_ready",  {31'd0, md_ready},  {31'd0, (m_q.size() < 2)});
    endtask

    task automatic idle_inputs();
        rst = 0; wb_valid = 0; wb_addr = 0; wb_data = 0;
        md_valid = 0; md_addr = 0; md_data = 0;
        md_issue = 0; md_issue_addr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    // ---------------------------------------------------------------------
    // Directed vector table: inputs for one cycle, expected state after it.
    // ---------------------------------------------------------------------
    typedef struct {
        logic        wv; logic [4:0] wa; logic [31:0] wd;
        logic        mv; logic [4:0] ma; logic [31:0] md;
        logic        mi; logic [4:0] mia;
        logic        e_we; logic [4:0] e_a3; logic [31:0] e_wd;
        logic [31:0] e_busy; logic e_err;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0,  1'b0};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0,  1'b0};
        vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 1'b0, 5'd5, 32'hDEADBEEF, 32'h80, 1'b0};
        vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 1'b0, 5'd5, 32'hDEADBEEF, 32'h80, 1'b0};
        vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 1'b1, 5'd7, 32'h11,       32'h0,  1'b0};
        vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd4, 1'b0, 5'd7, 32'h11,       32'h10, 1'b0};
        vecs[6]  = '{1'b1, 5'd0, 32'h99,       1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 1'b0, 5'd7, 32'h11,       32'h10, 1'b0};
        vecs[7]  = '{1'b1, 5'd0, 32'h77,       1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 1'b1, 5'd4, 32'h44,       32'h0,  1'b0};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 1'b0, 5'd4, 32'h44,       32'h0,  1'b0};
        vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 1'b0, 5'd4, 32'h44,       32'h0,  1'b0};
        vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd6, 1'b0, 5'd4, 32'h44,       32'h40, 1'b0};
        vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd6, 1'b0, 5'd4, 32'h44,       32'h40, 1'b1};
        vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 1'b0, 5'd4, 32'h44,       32'h40, 1'b1};
    end

    initial begin
        bit seen;
        #2;

        // Reset state
        do_reset();
        check("rst_WE3",  {31'd0, WE3}, 32'd0);
        check("rst_A3",   {27'd0, A3},  32'd0);
        check("rst_WD3",  WD3,          32'd0);
        check("rst_busy", busy_vec,     32'd0);
        check("rst_ready", {31'd0, md_ready}, 32'd1);
        check("rst_err",  {31'd0, err}, 32'd0);

        // Table-driven directed vectors
        for (int i = 0; i < 13; i++) begin
            idle_inputs();
            wb_valid = vecs[i].wv; wb_addr = vecs[i].wa; wb_data = vecs[i].wd;
            md_valid = vecs[i].mv; md_addr = vecs[i].ma; md_data = vecs[i].md;
            md_issue = vecs[i].mi; md_issue_addr = vecs[i].mia;
            tick();
            check($sformatf("vec%0d_WE3", i),  {31'd0, WE3}, {31'd0, vecs[i].e_we});
            check($sformatf("vec%0d_A3", i),   {27'd0, A3},  {27'd0, vecs[i].e_a3});
            check($sformatf("vec%0d_WD3", i),  WD3,          vecs[i].e_wd);
            check($sformatf("vec%0d_busy", i), busy_vec,     vecs[i].e_busy);
            check($sformatf("vec%0d_err", i),  {31'd0, err}, {31'd0, vecs[i].e_err});
        end

        // WB saturates the port while two MD results queue up
        do_reset();
        md_issue = 1; md_issue_addr = 9;  tick();
        md_issue_addr = 10;               tick();
        idle_inputs();
        wb_valid = 1; wb_addr = 3; wb_data = 32'h3333;
        md_valid = 1; md_addr = 9;  md_data = 32'h99; tick();
        md_addr = 10; md_data = 32'hAA;               tick();
        md_valid = 0;
        check("full_ready", {31'd0, md_ready}, 32'd0);
`ifdef RF_ARB_STARVE_GUARD_EN
        seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            if (stall_req) begin
                seen = 1;
                wb_valid = 0;
                tick();
                check("guard_WE3", {31'd0, WE3}, 32'd1);
                check("guard_A3",  {27'd0, A3},  32'd9);
                check("guard_WD3", WD3,          32'h99);
            end else begin
                tick();
            end
        end
        check("guard_stall_seen", {31'd0, seen}, 32'd1);
        wb_valid = 0;
        tick();
        tick();
`else
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("starve_A3", {27'd0, A3}, 32'd3);
        end
        wb_valid = 0;
        tick();
        check("drain_A3_9",  {27'd0, A3}, 32'd9);
        check("drain_WD3_9", WD3,         32'h99);
        tick();
        check("drain_A3_10", {27'd0, A3}, 32'd10);
        check("drain_busy",  busy_vec,    32'd0);
`endif
        check("starve_err", {31'd0, err}, 32'd0);

        // Reset discards a full FIFO and pending scoreboard bits
        do_reset();
        md_issue = 1; md_issue_addr = 9;  tick();
        md_issue_addr = 10;               tick();
        idle_inputs();
        wb_valid = 1; wb_addr = 3; wb_data = 32'h1;
        md_valid = 1; md_addr = 9;  md_data = 32'h5; tick();
        md_addr = 10; md_data = 32'h6;               tick();
        check("pre_rst_busy",  busy_vec, 32'h0000_0600);
        check("pre_rst_ready", {31'd0, md_ready}, 32'd0);
        rst = 1; md_issue = 1; md_issue_addr = 12;
        tick();
        check("rst_override_WE3",   {31'd0, WE3}, 32'd0);
        check("rst_override_busy",  busy_vec,     32'd0);
        check("rst_override_ready", {31'd0, md_ready}, 32'd1);
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_WE3", {31'd0, WE3}, 32'd0);
        end

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            idle_inputs();
            rst           = ($urandom_range(0, 59) == 0);
            wb_valid      = ($urandom_range(0, 1) == 1);
            wb_addr       = 5'($urandom_range(0, 7));
            wb_data       = $urandom;
            md_valid      = ($urandom_range(0, 2) != 0);
            md_addr       = 5'($urandom_range(0, 7));
            md_data       = $urandom;
            md_issue      = ($urandom_range(0, 2) == 0);
            md_issue_addr = 5'($urandom_range(0, 7));
            if (stall_req && $urandom_range(0, 3) != 0) wb_valid = 0;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
